// File: rtl/usb_rx_deserializer_if.sv
// USB receive-path bundle: raw D+/D- lines in, decoded byte stream and packet status out.
interface usb_rx_deserializer_if;
  logic       d_plus_in;
  logic       d_minus_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_error;
  logic       rx_active;
  logic [1:0] state_dbg;

  // rx_valid, rx_eop and rx_error are single-cycle strobes with no back-pressure: the consumer
  // takes rx_data in the cycle rx_valid is high; rx_data then holds until the next byte completes.
  modport master (input  d_plus_in, d_minus_in,
                  output rx_data, rx_valid, rx_eop, rx_error, rx_active, state_dbg);
  modport slave  (output d_plus_in, d_minus_in,
                  input  rx_data, rx_valid, rx_eop, rx_error, rx_active, state_dbg);
endinterface

// File: rtl/usb_rx_deserializer.sv
// USB full-speed receive deserializer: line synchronization, bit-phase recovery, NRZI decode,
// bit unstuffing and byte assembly, with EOP and error detection.
module usb_rx_deserializer #(
  parameter int BIT_CYCLES = 8,
  parameter int SAMPLE_PT  = 3
) (
  input logic                   tb_clk,
  input logic                   tb_n_rst,
  usb_rx_deserializer_if.master bus
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    EOP      = 2'd2,
    ERR_WAIT = 2'd3
  } state_t;

  state_t        state;
  logic          dp_meta, dp_sync, dm_meta, dm_sync;
  logic          dp_prev, dm_prev;
  logic [CW-1:0] phase_q;
  logic          nrzi_prev;
  logic [2:0]    ones_run;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          seen_se0;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, rx_eop_q, rx_error_q, rx_active_q;

  logic          line_j, line_k, line_se0, prev_j, dp_edge, bit_tick, nrzi_bit;
  logic [CW-1:0] phase;

  always_comb begin
    line_j   = dp_sync & ~dm_sync;
    line_k   = ~dp_sync & dm_sync;
    line_se0 = ~(line_j | line_k);  // SE1 folds into SE0
    prev_j   = dp_prev & ~dm_prev;
    dp_edge  = dp_sync ^ dp_prev;
    // Phase reads 0 in the cycle the edge is seen, so sampling lands SAMPLE_PT cycles after it.
    phase    = dp_edge ? '0 : phase_q;
    bit_tick = (phase == CW'(SAMPLE_PT));
    nrzi_bit = (dp_sync == nrzi_prev);
  end

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state       <= IDLE;
      dp_meta     <= 1'b1;
      dp_sync     <= 1'b1;
      dm_meta     <= 1'b0;
      dm_sync     <= 1'b0;
      dp_prev     <= 1'b1;
      dm_prev     <= 1'b0;
      phase_q     <= '0;
      nrzi_prev   <= 1'b1;
      ones_run    <= 3'd0;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      seen_se0    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_error_q  <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      dp_meta    <= bus.d_plus_in;
      dp_sync    <= dp_meta;
      dm_meta    <= bus.d_minus_in;
      dm_sync    <= dm_meta;
      dp_prev    <= dp_sync;
      dm_prev    <= dm_sync;
      phase_q    <= (phase == CW'(BIT_CYCLES - 1)) ? '0 : phase + CW'(1);
      rx_valid_q <= 1'b0;
      rx_eop_q   <= 1'b0;
      rx_error_q <= 1'b0;

      case (state)
        IDLE: begin
          if (prev_j && line_k) begin
            state       <= RECEIVE;
            rx_active_q <= 1'b1;
            // Idle J is the NRZI reference for the first SYNC bit, so SYNC decodes as 0x80.
            nrzi_prev   <= 1'b1;
            ones_run    <= 3'd0;
            bit_cnt     <= 3'd0;
            shift_q     <= 8'h00;
          end
        end

        RECEIVE: begin
          if (bit_tick) begin
            if (line_se0) begin
              state <= EOP;
            end else begin
              nrzi_prev <= dp_sync;
              if (ones_run == 3'd6) begin
                ones_run <= 3'd0;
                if (nrzi_bit) begin
                  state      <= ERR_WAIT;
                  rx_error_q <= 1'b1;
                  seen_se0   <= 1'b0;
                  bit_cnt    <= 3'd0;
                  shift_q    <= 8'h00;
                end
              end else begin
                ones_run <= nrzi_bit ? ones_run + 3'd1 : 3'd0;
                shift_q  <= {nrzi_bit, shift_q[7:1]};
                if (bit_cnt == 3'd7) begin
                  rx_data_q  <= {nrzi_bit, shift_q[7:1]};
                  rx_valid_q <= 1'b1;
                  bit_cnt    <= 3'd0;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
            end
          end
        end

        EOP: begin
          if (bit_tick) begin
            if (line_j) begin
              state       <= IDLE;
              rx_active_q <= 1'b0;
              rx_eop_q    <= (bit_cnt == 3'd0);
              rx_error_q  <= (bit_cnt != 3'd0);
              bit_cnt     <= 3'd0;
              shift_q     <= 8'h00;
              ones_run    <= 3'd0;
            end else if (line_k) begin
              state      <= ERR_WAIT;
              rx_error_q <= 1'b1;
              seen_se0   <= 1'b0;
            end
          end
        end

        ERR_WAIT: begin
          if (line_se0) begin
            seen_se0 <= 1'b1;
          end else if (line_j && seen_se0) begin
            state       <= IDLE;
            rx_active_q <= 1'b0;
            seen_se0    <= 1'b0;
            bit_cnt     <= 3'd0;
            shift_q     <= 8'h00;
            ones_run    <= 3'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_eop    = rx_eop_q;
  assign bus.rx_error  = rx_error_q;
  assign bus.rx_active = rx_active_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Bench for usb_rx_deserializer: NRZI/stuffing encoder drives the lines, a monitor pops
// expected {kind, data} events from a queue whenever the DUT strobes an output.
module tb_usb_rx_deserializer;
  localparam int         BC       = 8;
  localparam logic [1:0] LJ       = 2'b10;
  localparam logic [1:0] LK       = 2'b01;
  localparam logic [1:0] LSE0     = 2'b00;
  localparam logic [1:0] LSE1     = 2'b11;
  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_EOP   = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  logic tb_clk   = 1'b0;
  logic tb_n_rst = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  logic [9:0] exp_q[$];
  logic [1:0] lvl_q[$];
  logic       cur_dp;
  int         ones_m;
  int         jit_idx = 0;
  // No -2 is ever followed by +2 on consecutive D+ edges.
  int         jit_tab [0:7] = '{2, -2, 0, 1, -1, 2, -2, 1};

  usb_rx_deserializer_if bus ();

  usb_rx_deserializer #(.BIT_CYCLES(BC), .SAMPLE_PT(3)) dut (
    .tb_clk  (tb_clk),
    .tb_n_rst(tb_n_rst),
    .bus     (bus.master)
  );

  // clock / reset
  always #5 tb_clk = ~tb_clk;

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [1:0] kind, input logic [7:0] data);
    exp_q.push_back({kind, data});
  endtask

  // driver tasks: build a per-bit line-level list, then play it out
  task automatic start_pkt();
    lvl_q.delete();
    cur_dp = 1'b1;
    ones_m = 0;
    lvl_q.push_back(LJ);
    lvl_q.push_back(LJ);
  endtask

  task automatic enc_bit(input logic b, input bit stuff_en);
    if (!b) cur_dp = ~cur_dp;
    lvl_q.push_back({cur_dp, ~cur_dp});
    ones_m = b ? ones_m + 1 : 0;
    if (stuff_en && ones_m == 6) begin
      cur_dp = ~cur_dp;
      lvl_q.push_back({cur_dp, ~cur_dp});
      ones_m = 0;
    end
  endtask

  task automatic enc_byte(input logic [7:0] v, input bit stuff_en);
    for (int i = 0; i < 8; i++) enc_bit(v[i], stuff_en);
  endtask

  task automatic enc_lvl(input logic [1:0] lv, input int n);
    for (int i = 0; i < n; i++) lvl_q.push_back(lv);
    cur_dp = lv[1];
    ones_m = 0;
  endtask

  task automatic play(input bit jit_en, input int stop_at);
    int st[$];
    int n;
    int idx;
    int s;
    n = lvl_q.size();
    st.push_back(0);
    for (int i = 1; i < n; i++) begin
      s = i * BC;
      if (jit_en && (lvl_q[i][1] != lvl_q[i-1][1])) begin
        s = s + jit_tab[jit_idx % 8];
        jit_idx++;
      end
      st.push_back(s);
    end
    idx = 0;
    for (int c = 0; c < n * BC; c++) begin
      if (stop_at > 0 && c >= stop_at) break;
      while (idx + 1 < n && st[idx+1] <= c) idx++;
      bus.d_plus_in  = lvl_q[idx][1];
      bus.d_minus_in = lvl_q[idx][0];
      @(negedge tb_clk);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"},   {8'h00, bus.rx_data},     16'h0000);
    check({tag, "_rx_valid"},  {15'd0, bus.rx_valid},    16'h0000);
    check({tag, "_rx_eop"},    {15'd0, bus.rx_eop},      16'h0000);
    check({tag, "_rx_error"},  {15'd0, bus.rx_error},    16'h0000);
    check({tag, "_rx_active"}, {15'd0, bus.rx_active},   16'h0000);
    check({tag, "_state"},     {14'd0, bus.state_dbg},   16'h0000);
  endtask

  // scoreboard monitor
  always @(negedge tb_clk) begin
    if (tb_n_rst && (bus.rx_valid || bus.rx_eop || bus.rx_error)) begin
      logic [9:0] act;
      logic [9:0] exp;
      check("valid_eop_exclusive", {15'd0, bus.rx_valid & bus.rx_eop}, 16'h0000);
      act = bus.rx_valid ? {EV_VALID, bus.rx_data} :
            bus.rx_eop   ? {EV_EOP, 8'h00} : {EV_ERR, 8'h00};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        check("event", {6'd0, act}, {6'd0, exp});
      end
    end
  end

  initial begin
    bus.d_plus_in  = 1'b1;
    bus.d_minus_in = 1'b0;
    tb_n_rst       = 1'b0;
    repeat (3) @(negedge tb_clk);
    check_outputs_zero("reset");
    tb_n_rst = 1'b1;
    repeat (6) @(negedge tb_clk);

    // SYNC + 0xA5, 2-bit SE0, J
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'hA5, 1); enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'hA5); exp_push(EV_EOP, 8'h00);
    play(0, 0);
    check("rx_data_hold", {8'h00, bus.rx_data}, 16'h00A5);
    check("idle_after_eop", {15'd0, bus.rx_active}, 16'h0000);

    // 0xFF with a stuffed zero
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'hFF, 1); enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'hFF); exp_push(EV_EOP, 8'h00);
    play(0, 0);

    // seven ones in a row: stuff error, rest of packet ignored
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'hFF, 0); enc_byte(8'h00, 0);
    enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_ERR, 8'h00);
    play(0, 0);

    // SE0 after 3 bits of a byte
    start_pkt(); enc_byte(8'h80, 1); enc_bit(1'b1, 1); enc_bit(1'b0, 1); enc_bit(1'b1, 1);
    enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_ERR, 8'h00);
    play(0, 0);

    // clean packet after the partial-byte error
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'hC3, 1); enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'hC3); exp_push(EV_EOP, 8'h00);
    play(0, 0);

    // K during EOP, then SE0/J recovery
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'h01, 1); enc_lvl(LSE0, 1); enc_lvl(LK, 1);
    enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'h01); exp_push(EV_ERR, 8'h00);
    play(0, 0);
    check("idle_after_err_wait", {14'd0, bus.state_dbg}, 16'h0000);

    // SE1 treated as SE0
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'h42, 1); enc_lvl(LSE1, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'h42); exp_push(EV_EOP, 8'h00);
    play(0, 0);

    // reset mid-byte: 2 idle + 8 SYNC + 3 data bits, then abort
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'h55, 1); enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80);
    play(0, 13 * BC + 4);
    check("active_mid_byte", {15'd0, bus.rx_active}, 16'h0001);
    check("state_mid_byte", {14'd0, bus.state_dbg}, 16'h0001);
    tb_n_rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    bus.d_plus_in  = 1'b1;
    bus.d_minus_in = 1'b0;
    repeat (4) @(negedge tb_clk);
    tb_n_rst = 1'b1;
    repeat (10) @(negedge tb_clk);
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'h3C, 1); enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'h3C); exp_push(EV_EOP, 8'h00);
    play(0, 0);

    // +/-2 cycle edge jitter on every D+ transition
    start_pkt(); enc_byte(8'h80, 1); enc_byte(8'h5A, 1); enc_byte(8'hFF, 1);
    enc_byte(8'h00, 1); enc_byte(8'h7E, 1); enc_lvl(LSE0, 2); enc_lvl(LJ, 3);
    exp_push(EV_VALID, 8'h80); exp_push(EV_VALID, 8'h5A); exp_push(EV_VALID, 8'hFF);
    exp_push(EV_VALID, 8'h00); exp_push(EV_VALID, 8'h7E); exp_push(EV_EOP, 8'h00);
    play(1, 0);

    // final report
    repeat (20) @(negedge tb_clk);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
